// File: rtl/z8_fetch_unit.sv
// z8 instruction fetch stage: owns the PC, reads program memory, and hands instructions to decode.
// Optional macro Z8_FETCH_HALT_RESUME_EN lets a jump restart fetch after a HALT.
module z8_fetch_unit #(
  parameter int              PROG_MEM_SIZE    = 256,
  parameter int              INSTRUCTION_SIZE = 40,
  parameter int              PC_WIDTH         = 8,
  parameter logic [7:0]      HALT_OPCODE      = 8'hFE
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_rd_en,
  output logic [PC_WIDTH-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  output logic [INSTRUCTION_SIZE-1:0] instr_out,
  output logic [PC_WIDTH-1:0]         instr_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  input  logic                        jump_en,
  input  logic [PC_WIDTH-1:0]         jump_target,
  output logic                        halted
);

  if ((2 ** PC_WIDTH) != PROG_MEM_SIZE) begin : g_size_check
    $error("z8_fetch_unit: 2**PC_WIDTH must equal PROG_MEM_SIZE");
  end

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t                        state_q, state_d;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0]           ipc_q, ipc_d;
  logic                          valid_q, valid_d;
  logic [7:0]                    opcode;

  assign opcode = instr_q[INSTRUCTION_SIZE-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    // A redirect beats fetch, handshake and HALT detection in every active state.
    if (jump_en && (state_q != S_HALTED)) begin
      pc_d    = jump_target;
      valid_d = 1'b0;
      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = PC_WIDTH'(pc_q + 1'b1);
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            state_d = (opcode == HALT_OPCODE) ? S_HALTED : S_REQ;
          end
        end
        S_HALTED: begin
          valid_d = 1'b0;
`ifdef Z8_FETCH_HALT_RESUME_EN
          if (jump_en) begin
            pc_d    = jump_target;
            state_d = S_REQ;
          end
`else
          state_d = S_HALTED;
`endif
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // Reset leaves the FSM in REQ, so the strobe is masked until rst drops.
  assign imem_rd_en  = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_z8_fetch_unit.sv
// Scoreboard bench for z8_fetch_unit: expected {pc, instr} pushed on fetch stimulus, popped at handshake.
module tb_z8_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [39:0] imem_rdata = '0;
  logic [39:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_target = '0;
  logic        halted;

  typedef struct {
    logic [7:0]  pc;
    logic [39:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] mem [256];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  z8_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_en(jump_en), .jump_target(jump_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic push_exp(input logic [7:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem[pc];
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    for (int i = 0; i < budget && !instr_valid; i++) @(negedge clk);
    ok = instr_valid;
  endtask

  task automatic test_reset;
    exp_t e;
    bit   ok;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc, halted} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%b addr=%h v=%b out=%h pc=%h h=%b required all zero",
               imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc, halted);
    end
    rst = 1'b0;
    #1;
    total++;
    if (!(imem_rd_en === 1'b1 && imem_addr === 8'h00)) begin
      bad++;
      $display("FAIL first_strobe: got rd=%b addr=%h required rd=1 addr=00", imem_rd_en, imem_addr);
    end
    push_exp(8'h00);
    @(negedge clk);
    total++;
    if (imem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL wait_cycle: got rd=%b v=%b required 0 0", imem_rd_en, instr_valid);
    end
    wait_valid(1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL first_valid_latency: got valid=0 required valid=1 at cycle 3");
    end
    e = exp_q.pop_front();
    total++;
    if (instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL first_instr: got %h@%h required %h@%h", instr_out, instr_pc, e.ins, e.pc);
    end
    $display("txn reset pc=%h instr=%h", instr_pc, instr_out);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++;
    if (!(instr_valid === 1'b0 && imem_rd_en === 1'b1 && imem_addr === 8'h01)) begin
      bad++;
      $display("FAIL second_fetch: got v=%b rd=%b addr=%h required v=0 rd=1 addr=01",
               instr_valid, imem_rd_en, imem_addr);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    bit   ok;
    int   errs = 0;
    push_exp(8'h01);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL bp_instr: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (instr_valid !== 1'b1 || instr_out !== e.ins || instr_pc !== e.pc || imem_rd_en !== 1'b0)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_stable: got %0d unstable cycles required 0", errs);
    end
    $display("txn backpressure pc=%h instr=%h", instr_pc, instr_out);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++;
    if (!(instr_valid === 1'b0 && imem_rd_en === 1'b1 && imem_addr === 8'h02)) begin
      bad++;
      $display("FAIL bp_release: got v=%b rd=%b addr=%h required v=0 rd=1 addr=02",
               instr_valid, imem_rd_en, imem_addr);
    end
  endtask

  task automatic test_jump_hold;
    exp_t e;
    bit   ok;
    push_exp(8'h02);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL jh_pre: got v=%b pc=%h required pc=%h", ok, instr_pc, e.pc);
    end
    jump_en = 1'b1; jump_target = 8'h40; instr_ready = 1'b1;
    @(negedge clk);
    jump_en = 1'b0; instr_ready = 1'b0;
    total++;
    if (!(instr_valid === 1'b0 && imem_rd_en === 1'b1 && imem_addr === 8'h40 && halted === 1'b0)) begin
      bad++;
      $display("FAIL jh_redirect: got v=%b rd=%b addr=%h h=%b required v=0 rd=1 addr=40 h=0",
               instr_valid, imem_rd_en, imem_addr, halted);
    end
    push_exp(8'h40);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL jh_target: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    $display("txn jump_hold pc=%h instr=%h", instr_pc, instr_out);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_jump_wait;
    exp_t e;
    bit   ok;
    @(negedge clk);
    jump_en = 1'b1; jump_target = 8'h10;
    @(negedge clk);
    jump_en = 1'b0;
    total++;
    if (!(instr_valid === 1'b0 && imem_rd_en === 1'b1 && imem_addr === 8'h10)) begin
      bad++;
      $display("FAIL jw_redirect: got v=%b rd=%b addr=%h required v=0 rd=1 addr=10",
               instr_valid, imem_rd_en, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL jw_discard: got valid=%b required 0", instr_valid);
    end
    push_exp(8'h10);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL jw_target: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    $display("txn jump_wait pc=%h instr=%h", instr_pc, instr_out);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_halt;
    exp_t e;
    bit   ok;
    int   strobes = 0;
    int   unhalt = 0;
    jump_en = 1'b1; jump_target = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    total++;
    if (!(imem_rd_en === 1'b1 && imem_addr === 8'hFF)) begin
      bad++;
      $display("FAIL jr_redirect: got rd=%b addr=%h required rd=1 addr=ff", imem_rd_en, imem_addr);
    end
    push_exp(8'hFF);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL halt_instr: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    $display("txn halt pc=%h instr=%h", instr_pc, instr_out);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total++;
    if (!(halted === 1'b1 && instr_valid === 1'b0 && imem_addr === 8'h00)) begin
      bad++;
      $display("FAIL halt_state: got h=%b v=%b pc=%h required h=1 v=0 pc=00", halted, instr_valid, imem_addr);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_rd_en !== 1'b0) strobes++;
      if (halted !== 1'b1) unhalt++;
    end
    total++;
    if (strobes != 0 || unhalt != 0) begin
      bad++;
      $display("FAIL halt_idle: got strobes=%0d unhalted=%0d required 0 0", strobes, unhalt);
    end
    jump_en = 1'b1; jump_target = 8'h05;
    @(negedge clk);
    jump_en = 1'b0;
`ifdef Z8_FETCH_HALT_RESUME_EN
    total++;
    if (!(halted === 1'b0 && imem_rd_en === 1'b1 && imem_addr === 8'h05)) begin
      bad++;
      $display("FAIL resume: got h=%b rd=%b addr=%h required h=0 rd=1 addr=05", halted, imem_rd_en, imem_addr);
    end
    push_exp(8'h05);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL resume_instr: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    $display("txn resume pc=%h instr=%h", instr_pc, instr_out);
`else
    total++;
    if (!(halted === 1'b1 && imem_rd_en === 1'b0 && imem_addr === 8'h00)) begin
      bad++;
      $display("FAIL no_resume: got h=%b rd=%b addr=%h required h=1 rd=0 addr=00", halted, imem_rd_en, imem_addr);
    end
`endif
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_exp(8'h00);
    wait_valid(6, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
      bad++;
      $display("FAIL rm_pre: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
    end
    instr_ready = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc, halted} !== '0) begin
      bad++;
      $display("FAIL rm_async: got rd=%b addr=%h v=%b out=%h pc=%h h=%b required all zero",
               imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc, halted);
    end
    @(negedge clk);
    instr_ready = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (!(imem_rd_en === 1'b1 && imem_addr === 8'h00 && instr_valid === 1'b0)) begin
      bad++;
      $display("FAIL rm_restart: got rd=%b addr=%h v=%b required rd=1 addr=00 v=0",
               imem_rd_en, imem_addr, instr_valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   ok;
    int   last_cyc = 0;
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_exp(8'(k));
      wait_valid(8, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || instr_out !== e.ins || instr_pc !== e.pc) begin
        bad++;
        $display("FAIL b2b_instr: got v=%b %h@%h required %h@%h", ok, instr_out, instr_pc, e.ins, e.pc);
      end
      if (k > 0) begin
        total++;
        if (cyc - last_cyc != 3) begin
          bad++;
          $display("FAIL b2b_rate: got %0d cycles required 3", cyc - last_cyc);
        end
      end
      $display("txn b2b pc=%h instr=%h cyc=%0d", instr_pc, instr_out, cyc);
      last_cyc = cyc;
      @(negedge clk);
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'h01, 8'(i), 8'hA5, 8'(~i), 8'(i * 3)};
    mem[0]   = 40'h0301000005;
    mem[1]   = 40'h0000000000;
    mem[255] = 40'hFE00000000;
    test_reset;
    test_backpressure;
    test_jump_hold;
    test_jump_wait;
    test_halt;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z8_fetch_unit.md
Name: z8_fetch_unit

Overview:
Instruction fetch stage of the z8 core, directly upstream of decode. It owns the program counter and reads one 40-bit instruction per fetch from program memory. It presents the instruction to decode over a valid/ready handshake and accepts jump redirects from execute. It stops fetching when it issues a HALT (0xFE) instruction.

Parameters:
PROG_MEM_SIZE, 256, program memory depth in instructions
INSTRUCTION_SIZE, 40, instruction width; opcode in bits [39:32]
PC_WIDTH, 8, program counter width; must satisfy 2**PC_WIDTH == PROG_MEM_SIZE
HALT_OPCODE, 8'hFE, opcode that stops fetching

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_rd_en  out  1  program memory read strobe
imem_addr  out  PC_WIDTH  program memory address
imem_rdata  in  INSTRUCTION_SIZE  read data, valid exactly 1 cycle after imem_rd_en
instr_out  out  INSTRUCTION_SIZE  fetched instruction to decode
instr_pc  out  PC_WIDTH  address instr_out was fetched from
instr_valid  out  1  instr_out/instr_pc valid
instr_ready  in  1  decode accepts instruction
jump_en  in  1  redirect request from execute, single-cycle pulse
jump_target  in  PC_WIDTH  redirect address
halted  out  1  fetch stopped on HALT

Behaviour:
- Reset (async, rst high): pc=0, state=REQ, imem_rd_en=0, imem_addr=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0. First read strobe occurs in the first cycle after rst deasserts.
- imem_addr is always driven from pc. imem_rd_en=1 only in REQ.
- States: REQ, WAIT, HOLD, HALTED.
- REQ: assert imem_rd_en; next state is WAIT.
- WAIT: register imem_rdata into instr_out and pc into instr_pc, set instr_valid=1, and set pc<=pc+1 with modulo 2**PC_WIDTH wrap (0xFF -> 0x00). Next state is HOLD.
- HOLD: hold instr_out, instr_pc and instr_valid stable until instr_valid && instr_ready. On handshake, instr_valid goes 0 next cycle. If the accepted opcode equals HALT_OPCODE, go to HALTED. Otherwise go to REQ.
- Minimum throughput is 1 instruction per 3 cycles, with ready held high.
- jump_en has priority over every other event in REQ, WAIT and HOLD. It sets pc<=jump_target, sets instr_valid<=0 and goes to REQ.
  - In WAIT, the in-flight read data is discarded.
  - In HOLD, the held instruction is discarded even if instr_ready=1 in the same cycle. That instruction does not count as accepted, and the HALT check is not applied to it.
  - In REQ, the issued read is discarded. The next REQ uses jump_target.
- HALTED: halted=1, imem_rd_en=0, instr_valid=0, pc frozen at HALT address + 1. Only rst exits this state, unless the optional feature is enabled.
- A HALT at address 0xFF leaves pc=0x00 (wrap).
- rst asserted mid-operation clears all state immediately; no partial handshake completes.

Optional Feature:
Macro Z8_FETCH_HALT_RESUME_EN.
- Enabled: jump_en in HALTED clears halted, loads pc<=jump_target and goes to REQ on the next edge.
- Disabled: jump_en is ignored in HALTED.

Test Plan:
- Reset release, mem[0]=0x0301000005, mem[1]=0x0000000000, ready=1 -> rd_en at cycle 1, addr=0. instr_valid at cycle 3 with instr_out=0x0301000005 and instr_pc=0. Second fetch addr=1.
- Backpressure: ready=0 for 5 cycles while valid -> instr_out/instr_pc stable, no rd_en. Ready=1 -> one handshake, next rd_en 1 cycle later.
- Jump in HOLD with ready=1 same cycle, target 0x40 -> instruction dropped, next rd_en addr=0x40, next valid has instr_pc=0x40.
- Jump in WAIT, target 0x10 -> mem data discarded, instr_valid stays 0, fetch resumes at 0x10.
- mem[0xFF]=0xFE00000000 reached by jump to 0xFF, accepted -> halted=1, pc=0x00, no rd_en for 20 cycles. A jump_en to 0x05 restarts fetch at 0x05 with the macro on; without the macro it has no effect.
- rst pulsed during HOLD -> all outputs 0 asynchronously; fetch restarts at addr 0.
